// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divide unit: FSM states, funct3 encodings
// and the iteration count.
package div_sequencer_pkg;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract the divisor.
module div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shifted;
  logic [32:0] w_diff;
  logic        w_fits;

  assign w_shifted = {i_rem, i_quo[31]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  // The running remainder stays below the divisor, so bit 32 is the borrow.
  assign w_fits    = ~w_diff[32];
  assign o_rem     = w_fits ? w_diff[31:0] : w_shifted[31:0];
  assign o_quo     = {i_quo[30:0], w_fits};

endmodule

// File: rtl/div_sequencer.sv
// Sequencer for DIV/DIVU/REM/REMU: stalls the E stage while a 32-step restoring
// divide runs on operand magnitudes, then applies the sign fixup and pulses done.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        div_stall,
  output logic        done,
  output logic [31:0] result
);

  div_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_funct3;
  logic [31:0]      r_rem, r_quo, r_divisor, r_result;
  logic             r_neg_q, r_neg_r;

  logic        w_signed, w_neg_a, w_neg_b, w_div_zero, w_overflow, w_launch;
  logic [31:0] w_abs_a, w_abs_b, w_step_rem, w_step_quo, w_q_fix, w_r_fix, w_final;

  assign w_signed   = is_signed_op(funct3);
  assign w_neg_a    = w_signed & operand_a[31];
  assign w_neg_b    = w_signed & operand_b[31];
  assign w_abs_a    = w_neg_a ? -operand_a : operand_a;
  assign w_abs_b    = w_neg_b ? -operand_b : operand_b;
  assign w_div_zero = (operand_b == 32'h0);
  assign w_overflow = w_signed && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;
  assign w_final = is_rem_op(r_funct3) ? w_r_fix : w_q_fix;
  assign result  = done ? w_final : r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output is assigned a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    div_stall = 1'b0;
    done      = 1'b0;
    w_launch  = 1'b0;
    unique case (r_state)
      IDLE: if (start) begin
        w_launch  = 1'b1;
        div_stall = 1'b1;
        w_next    = (w_div_zero || w_overflow) ? DONE : BUSY;
      end
      BUSY: begin
        div_stall = 1'b1;
        if (r_count == '0) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset is gated here too so the combinational stall cannot leak out while it is held.
    if (flush || rst) begin
      w_next    = IDLE;
      div_stall = 1'b0;
      done      = 1'b0;
      w_launch  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and every datapath
  // register is reset, so result reads 0 while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_funct3  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_funct3  <= funct3;
        r_divisor <= w_abs_b;
        r_neg_r   <= w_neg_a;
        r_neg_q   <= (w_neg_a ^ w_neg_b) & ~w_div_zero;
        r_count   <= CNT_W'(DIV_ITERS - 1);
        if (w_div_zero) begin
          r_quo <= 32'hFFFF_FFFF;
          r_rem <= w_abs_a;
        end else if (w_overflow) begin
          r_quo <= 32'h8000_0000;
          r_rem <= 32'h0;
        end else begin
          r_quo <= w_abs_a;
          r_rem <= 32'h0;
        end
      end else if (r_state == BUSY) begin
        r_rem   <= w_step_rem;
        r_quo   <= w_step_quo;
        r_count <= r_count - CNT_W'(1);
      end
      if (done) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model, scoreboard
// compare process and directed vectors with hand-computed results.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = F3_DIVU;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        div_stall, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          stall;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_run = 0;
  logic [31:0] last_exp = '0;
  bit          mon_on = 1'b0;

  div_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .div_stall (div_stall),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics with plain integer arithmetic.
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (f == F3_DIV) || (f == F3_REM);
    bit rem = (f == F3_REM) || (f == F3_REMU);
    int sa = a;
    int sb = b;
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return rem ? r : q;
  endfunction

  function automatic int model_stall(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (f == F3_DIV) || (f == F3_REM);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Scoreboard: every done pops one expectation; outside done the result must hold.
  always @(negedge clk) begin
    if (rst) begin
      stall_run = 0;
      last_exp  = '0;
    end else if (mon_on) begin
      if (div_stall) stall_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_stall_cycles"}, 32'(stall_run), 32'(e.stall));
          last_exp = e.res;
        end
        stall_run = 0;
      end else begin
        check("result_hold", result, last_exp);
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({name, "_timeout"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    funct3    = f;
    operand_a = a;
    operand_b = b;
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
    exp_t e;
    e.res   = model_res(f, a, b);
    e.stall = model_stall(f, a, b);
    e.name  = name;
    exp_q.push_back(e);
    drive(f, a, b);
    wait_done(name);
  endtask

  // Hand-computed expectations: pin the model, then expect the literal from the DUT.
  task automatic run_lit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int lit_stall, input string name);
    exp_t e;
    check({name, "_model"}, model_res(f, a, b), lit);
    check({name, "_model_stall"}, 32'(model_stall(f, a, b)), 32'(lit_stall));
    e.res   = lit;
    e.stall = lit_stall;
    e.name  = name;
    exp_q.push_back(e);
    drive(f, a, b);
    wait_done(name);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with start already high: every output must stay 0.
    drive(F3_DIVU, 32'd100, 32'd7);
    repeat (2) begin
      @(negedge clk);
      check("reset_div_stall", 32'(div_stall), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    start  = 1'b0;
    mon_on = 1'b1;
    idle(2);

    // Directed vectors, issued back to back with start held high.
    run_lit(F3_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run_lit(F3_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run_lit(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_lit(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_lit(F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
    run_lit(F3_REM, 32'd5, 32'd0, 32'd5, 1, "rem_5_0");
    run_lit(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_lit(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
    run_lit(F3_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div_100_m7");
    run_lit(F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, "rem_m100_7");
    run_lit(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, "divu_big");
    run(F3_DIV, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
    run(F3_REM, 32'hFFFF_FFFB, 32'd0, "rem_m5_0");
    run(F3_DIV, 32'h8000_0000, 32'd1, "div_min_1");
    run(F3_REMU, 32'h1234_5678, 32'h0000_1000, "remu_mask");
    run(F3_DIVU, 32'hFFFF_FFFF, 32'd3, "divu_max_3");
    idle(3);

    // Flush on BUSY cycle 10: stall drops at once, no done, IDLE next cycle.
    drive(F3_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    flush     = 1'b1;
    start     = 1'b0;
    stall_run = 0;
    @(negedge clk);
    check("flush_div_stall", 32'(div_stall), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    run(F3_REMU, 32'd1000, 32'd7, "after_flush");
    idle(3);

    // Flush and start together in IDLE: nothing may start.
    drive(F3_DIV, 32'd77, 32'd5);
    flush = 1'b1;
    @(negedge clk);
    check("flush_start_div_stall", 32'(div_stall), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    idle(40);

    // Reset mid-BUSY: abandon the operation, outputs 0 while held, no late done.
    drive(F3_DIVU, 32'd12345, 32'd67);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_div_stall", 32'(div_stall), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(45);
    run(F3_DIVU, 32'd12345, 32'd67, "after_reset");
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
